// File: rtl/stack_pkg.sv
// Shared operand-stack command encoding and legality check, used by the stack and the ALU sequencer.
package stack_pkg;

   typedef enum logic [2:0] {
      NOP     = 3'd0,
      PUSH    = 3'd1,
      POP     = 3'd2,
      REPLACE = 3'd3,
      DUP     = 3'd4,
      SWAP    = 3'd5,
      CLEAR   = 3'd6
   } stack_op_e;

   // Reserved encodings fall through to legal so they act as a silent NOP.
   function automatic logic is_legal(stack_op_e op, int unsigned cnt, int unsigned depth);
      case (op)
         PUSH:          return cnt < depth;
         POP:           return cnt >= 1;
         REPLACE, SWAP: return cnt >= 2;
         DUP:           return (cnt >= 1) && (cnt < depth);
         default:       return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/stack_ptr_ctr.sv
// Saturating up/down entry counter with synchronous load-zero; async active-low reset.
module stack_ptr_ctr
   import stack_pkg::*;
#(
   parameter int CNT_W = 6,
   parameter int MAX   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt_q
);

   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !dec && (cnt_q < CNT_W'(MAX))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (dec && !inc && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO operand stack with command interface and overflow/underflow reporting.
// STACK_STICKY_ERR_EN: when defined, error flags hold until CLEAR/reset; otherwise they pulse one cycle.
module param_stack
   import stack_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 32,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] stack_top,
   output logic [WIDTH-1:0] stack_next,
   output logic [CNT_W-1:0] numcnt,
   output logic             full,
   output logic             empty,
   output logic             err_ovf,
   output logic             err_udf
);

   localparam int AW = $clog2(DEPTH);

   stack_op_e        op_e;
   logic [CNT_W-1:0] cnt_q;
   logic [AW-1:0]    idx0, idx1, idx2;
   logic             legal;
   logic             inc, dec, clr;
   logic             wr_en, sw_en;
   logic [AW-1:0]    wr_idx, sw_idx;
   logic [WIDTH-1:0] wr_data, sw_data;
   logic             ovf_set, udf_set;
   logic             err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   assign op_e  = stack_op_e'(op);
   assign idx0  = cnt_q[AW-1:0];
   assign idx1  = AW'(cnt_q - CNT_W'(1));
   assign idx2  = AW'(cnt_q - CNT_W'(2));
   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);
   assign legal = is_legal(op_e, 32'(cnt_q), DEPTH);

   always_comb begin
      inc     = 1'b0;
      dec     = 1'b0;
      clr     = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = idx0;
      wr_data = data_in;
      sw_en   = 1'b0;
      sw_idx  = idx2;
      sw_data = mem_q[idx1];
      ovf_set = 1'b0;
      udf_set = 1'b0;
      if (op_e == CLEAR) begin
         clr = 1'b1;
      end else if (legal) begin
         case (op_e)
            PUSH: begin
               wr_en = 1'b1;
               inc   = 1'b1;
            end
            POP: dec = 1'b1;
            REPLACE: begin
               wr_en  = 1'b1;
               wr_idx = idx2;
               dec    = 1'b1;
            end
            DUP: begin
               wr_en   = 1'b1;
               wr_data = mem_q[idx1];
               inc     = 1'b1;
            end
            SWAP: begin
               wr_en   = 1'b1;
               wr_idx  = idx1;
               wr_data = mem_q[idx2];
               sw_en   = 1'b1;
            end
            default: ;
         endcase
      end else if (((op_e == PUSH) || (op_e == DUP)) && full) begin
         ovf_set = 1'b1;
      end else begin
         // DEPTH>=4 means DUP cannot be both empty and full, so any other illegal op is underflow.
         udf_set = 1'b1;
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_idx] = wr_data;
      if (sw_en) mem_d[sw_idx] = sw_data;
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_comb begin
`ifdef STACK_STICKY_ERR_EN
      err_ovf_d = clr ? 1'b0 : (err_ovf_q | ovf_set);
      err_udf_d = clr ? 1'b0 : (err_udf_q | udf_set);
`else
      err_ovf_d = ovf_set;
      err_udf_d = udf_set;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         err_ovf_q <= err_ovf_d;
         err_udf_q <= err_udf_d;
      end
   end

   stack_ptr_ctr #(
      .CNT_W (CNT_W),
      .MAX   (DEPTH)
   ) u_ptr (
      .clk   (clk),
      .rst_n (rst),
      .inc   (inc),
      .dec   (dec),
      .clr   (clr),
      .cnt_q (cnt_q)
   );

   assign numcnt     = cnt_q;
   assign stack_top  = (cnt_q != '0)           ? mem_q[idx1] : '0;
   assign stack_next = (cnt_q >= CNT_W'(2))    ? mem_q[idx2] : '0;
   assign err_ovf    = err_ovf_q;
   assign err_udf    = err_udf_q;

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack: a 32x4 and an 8x32 instance share one op stream against an array model.
module tb_param_stack;
   import stack_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  op;
   logic [31:0] din;

   always #5 clk = ~clk;

   logic [31:0] a_top, a_next;
   logic [2:0]  a_cnt;
   logic        a_full, a_empty, a_ovf, a_udf;
   logic [7:0]  b_top, b_next;
   logic [5:0]  b_cnt;
   logic        b_full, b_empty, b_ovf, b_udf;

   param_stack #(.WIDTH(32), .DEPTH(4)) dut_a (
      .clk(clk), .rst(rst), .op(op), .data_in(din),
      .stack_top(a_top), .stack_next(a_next), .numcnt(a_cnt),
      .full(a_full), .empty(a_empty), .err_ovf(a_ovf), .err_udf(a_udf)
   );

   param_stack #(.WIDTH(8), .DEPTH(32)) dut_b (
      .clk(clk), .rst(rst), .op(op), .data_in(din[7:0]),
      .stack_top(b_top), .stack_next(b_next), .numcnt(b_cnt),
      .full(b_full), .empty(b_empty), .err_ovf(b_ovf), .err_udf(b_udf)
   );

   typedef struct {
      logic [31:0] top;
      logic [31:0] nxt;
      int unsigned cnt;
      logic        full;
      logic        empty;
      logic        ovf;
      logic        udf;
   } exp_t;

   exp_t        qa[$];
   exp_t        qb[$];
   logic [31:0] m [2][32];
   int unsigned mc [2];
   logic        meo [2];
   logic        meu [2];
   int          vectors = 0;
   int          errors  = 0;

   function automatic int unsigned dep_of(int i);
      return (i == 0) ? 4 : 32;
   endfunction

   function automatic void mreset();
      for (int i = 0; i < 2; i++) begin
         mc[i]  = 0;
         meo[i] = 1'b0;
         meu[i] = 1'b0;
      end
   endfunction

   function automatic exp_t snap(int i);
      exp_t e;
      e.cnt   = mc[i];
      e.top   = (mc[i] >= 1) ? m[i][mc[i]-1] : 32'd0;
      e.nxt   = (mc[i] >= 2) ? m[i][mc[i]-2] : 32'd0;
      e.full  = (mc[i] == dep_of(i));
      e.empty = (mc[i] == 0);
      e.ovf   = meo[i];
      e.udf   = meu[i];
      return e;
   endfunction

   function automatic void mstep(int i, logic [2:0] o, logic [31:0] d);
      int unsigned dep = dep_of(i);
      int unsigned c   = mc[i];
      logic [31:0] dv  = (i == 0) ? d : {24'd0, d[7:0]};
      logic        ov  = 1'b0;
      logic        un  = 1'b0;
      logic [31:0] t;
      case (o)
         3'd1: if (c == dep) ov = 1'b1; else begin m[i][c] = dv; c++; end
         3'd2: if (c < 1) un = 1'b1; else c--;
         3'd3: if (c < 2) un = 1'b1; else begin m[i][c-2] = dv; c--; end
         3'd4: if (c == dep) ov = 1'b1;
               else if (c < 1) un = 1'b1;
               else begin m[i][c] = m[i][c-1]; c++; end
         3'd5: if (c < 2) un = 1'b1;
               else begin t = m[i][c-1]; m[i][c-1] = m[i][c-2]; m[i][c-2] = t; end
         3'd6: begin c = 0; meo[i] = 1'b0; meu[i] = 1'b0; end
         default: ;
      endcase
      mc[i] = c;
`ifdef STACK_STICKY_ERR_EN
      meo[i] = meo[i] | ov;
      meu[i] = meu[i] | un;
`else
      meo[i] = ov;
      meu[i] = un;
`endif
   endfunction

   function automatic void cmp(string nm, exp_t e, exp_t a);
      vectors++;
      if (a.top !== e.top || a.nxt !== e.nxt || a.cnt !== e.cnt || a.full !== e.full ||
          a.empty !== e.empty || a.ovf !== e.ovf || a.udf !== e.udf) begin
         errors++;
         $display("FAIL %s @%0t: got top=%0h next=%0h cnt=%0d full=%b empty=%b ovf=%b udf=%b; want top=%0h next=%0h cnt=%0d full=%b empty=%b ovf=%b udf=%b",
                  nm, $time, a.top, a.nxt, a.cnt, a.full, a.empty, a.ovf, a.udf,
                  e.top, e.nxt, e.cnt, e.full, e.empty, e.ovf, e.udf);
      end
   endfunction

   // Monitor: checks the expected state after each clock edge and after an async reset assertion.
   always @(posedge clk or negedge rst) begin
      exp_t act;
      #1;
      if (qa.size() != 0) begin
         act.top = a_top; act.nxt = a_next; act.cnt = a_cnt;
         act.full = a_full; act.empty = a_empty; act.ovf = a_ovf; act.udf = a_udf;
         cmp("stack32x4", qa.pop_front(), act);
      end
      if (qb.size() != 0) begin
         act.top = {24'd0, b_top}; act.nxt = {24'd0, b_next}; act.cnt = b_cnt;
         act.full = b_full; act.empty = b_empty; act.ovf = b_ovf; act.udf = b_udf;
         cmp("stack8x32", qb.pop_front(), act);
      end
   end

   task automatic apply(input logic [2:0] o, input logic [31:0] d);
      @(negedge clk);
      op  = o;
      din = d;
      mstep(0, o, d);
      mstep(1, o, d);
      qa.push_back(snap(0));
      qb.push_back(snap(1));
   endtask

   task automatic reset_mid_push(input logic [31:0] d);
      @(negedge clk);
      op  = PUSH;
      din = d;
      #2;
      mreset();
      qa.push_back(snap(0));
      qb.push_back(snap(1));
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      op  = NOP;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  o;
      logic [31:0] d;
      int unsigned r;
      rst = 1'b0;
      op  = NOP;
      din = '0;
      mreset();
      repeat (2) @(negedge clk);
      qa.push_back(snap(0));
      qb.push_back(snap(1));
      @(negedge clk);
      rst = 1'b1;

      apply(PUSH, 5);    apply(PUSH, 7);
      apply(REPLACE, 12);
      apply(CLEAR, 0);
      for (int i = 1; i <= 4; i++) apply(PUSH, 32'(i));
      apply(PUSH, 9);    apply(NOP, 0);   apply(NOP, 0);
      apply(CLEAR, 0);
      apply(POP, 0);     apply(NOP, 0);
      apply(PUSH, 3);    apply(SWAP, 0);  apply(NOP, 0);
      apply(CLEAR, 0);
      apply(PUSH, 3);    apply(PUSH, 8);  apply(SWAP, 0);  apply(DUP, 0);
      apply(CLEAR, 0);
      apply(DUP, 0);     apply(REPLACE, 1); apply(3'd7, 0);
      apply(CLEAR, 0);
      apply(PUSH, 1);    apply(PUSH, 2);  apply(PUSH, 3);
      reset_mid_push(32'h99);
      apply(PUSH, 6);
      apply(CLEAR, 0);
      for (int i = 1; i <= 33; i++) apply(PUSH, 32'(i * 7));
      apply(DUP, 0);     apply(NOP, 0);   apply(POP, 0);   apply(DUP, 0);
      apply(CLEAR, 0);

      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 15);
         d = $urandom();
         if (r <= 5)       o = PUSH;
         else if (r <= 7)  o = POP;
         else if (r == 8)  o = REPLACE;
         else if (r == 9)  o = DUP;
         else if (r == 10) o = SWAP;
         else if (r == 11) o = NOP;
         else if (r == 12) o = 3'd7;
         else if (r == 13 && $urandom_range(0, 5) == 0) o = CLEAR;
         else              o = PUSH;
         apply(o, d);
         if (n == 300) reset_mid_push(d);
      end
      apply(NOP, 0);

      repeat (4) @(negedge clk);
      vectors++;
      if (qa.size() != 0 || qb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", qa.size(), qb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
